// File: rtl/alarm_controller_pkg.sv
// Shared definitions for the alarm controller: field widths, time limits,
// FSM state codes and a small range-check helper.
package alarm_controller_pkg;

    localparam int HH_W = 5;
    localparam int MM_W = 6;
    localparam int SS_W = 6;
    localparam int ST_W = 2;

    localparam logic [HH_W-1:0] MAX_HH = 5'd23;
    localparam logic [MM_W-1:0] MAX_MM = 6'd59;
    localparam logic [SS_W-1:0] MAX_SS = 6'd59;

    // State codes are visible on the state output, so the values are fixed.
    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_ARMED   = 2'd1;
    localparam logic [ST_W-1:0] ST_RINGING = 2'd2;
    localparam logic [ST_W-1:0] ST_SNOOZE  = 2'd3;

    // Hours/minutes pair, used for the programmed alarm time.
    typedef struct packed {
        logic [HH_W-1:0] hh;
        logic [MM_W-1:0] mm;
    } hm_t;

    // True when an hh:mm pair is a legal time of day.
    function automatic logic hm_valid(input logic [HH_W-1:0] h,
                                      input logic [MM_W-1:0] m);
        return (h <= MAX_HH) && (m <= MAX_MM);
    endfunction

endpackage

// File: rtl/alarm_controller_tod_counter.sv
// Time-of-day counter: second prescaler, registered sec_tick, hh:mm:ss with
// wrap/carry, and the set_time load (which restarts the current second).
module tod_counter
    import alarm_controller_pkg::*;
#(
    parameter int CLK_PER_SEC = 20_000_000
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            set_time,
    input  logic [HH_W-1:0] time_hh,
    input  logic [MM_W-1:0] time_mm,
    output logic [HH_W-1:0] hh,
    output logic [MM_W-1:0] mm,
    output logic [SS_W-1:0] ss,
    output logic            sec_tick
);

    localparam int              PRE_W   = $clog2(CLK_PER_SEC);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_SEC - 1);

    logic [PRE_W-1:0] pre_q,  pre_d;
    logic [HH_W-1:0]  hh_q,   hh_d;
    logic [MM_W-1:0]  mm_q,   mm_d;
    logic [SS_W-1:0]  ss_q,   ss_d;
    logic             tick_q, tick_d;
    logic             load;
    logic             wrap;

    assign load = set_time && hm_valid(time_hh, time_mm);
    assign wrap = (pre_q == PRE_MAX);

    // Next-state for prescaler and time; a valid load beats a same-cycle wrap.
    always_comb begin
        pre_d  = pre_q;
        hh_d   = hh_q;
        mm_d   = mm_q;
        ss_d   = ss_q;
        tick_d = 1'b0;
        if (load) begin
            pre_d = '0;
            hh_d  = time_hh;
            mm_d  = time_mm;
            ss_d  = '0;
        end else if (wrap) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (ss_q == MAX_SS) begin
                ss_d = '0;
                if (mm_q == MAX_MM) begin
                    mm_d = '0;
                    hh_d = (hh_q == MAX_HH) ? '0 : hh_q + 1'b1;
                end else begin
                    mm_d = mm_q + 1'b1;
                end
            end else begin
                ss_d = ss_q + 1'b1;
            end
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Time registers with asynchronous clear to 00:00:00.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pre_q  <= '0;
            hh_q   <= '0;
            mm_q   <= '0;
            ss_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            hh_q   <= hh_d;
            mm_q   <= mm_d;
            ss_q   <= ss_d;
            tick_q <= tick_d;
        end
    end

    assign hh       = hh_q;
    assign mm       = mm_q;
    assign ss       = ss_q;
    assign sec_tick = tick_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller top: alarm registers, match compare, arm/ring/snooze FSM
// with its second counters, and the buzzer-driver enable.
module alarm_controller
    import alarm_controller_pkg::*;
#(
    parameter int CLK_PER_SEC      = 20_000_000,
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            arm,
    input  logic            set_time,
    input  logic [HH_W-1:0] time_hh,
    input  logic [MM_W-1:0] time_mm,
    input  logic            set_alarm,
    input  logic [HH_W-1:0] alarm_hh,
    input  logic [MM_W-1:0] alarm_mm,
    input  logic            snooze,
    input  logic            dismiss,
    output logic            enable,
    output logic [HH_W-1:0] hh,
    output logic [MM_W-1:0] mm,
    output logic [SS_W-1:0] ss,
    output logic            sec_tick,
    output logic [ST_W-1:0] state
);

    // +1 so a power-of-two load value still fits.
    localparam int               RING_W    = $clog2(RING_TIMEOUT_SEC + 1);
    localparam int               SNZ_W     = $clog2(SNOOZE_SEC + 1);
    localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_TIMEOUT_SEC);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SEC);

    hm_t              alarm_q,  alarm_d;
    logic [ST_W-1:0]  state_q,  state_d;
    logic [RING_W-1:0] ring_q,  ring_d;
    logic [SNZ_W-1:0] snz_q,    snz_d;
    logic [RING_W-1:0] ring_dec;
    logic [SNZ_W-1:0] snz_dec;
    logic             match;

    tod_counter #(
        .CLK_PER_SEC (CLK_PER_SEC)
    ) u_tod (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .set_time (set_time),
        .time_hh  (time_hh),
        .time_mm  (time_mm),
        .hh       (hh),
        .mm       (mm),
        .ss       (ss),
        .sec_tick (sec_tick)
    );

    // Only a counted second landing on :00 matches; a set_time load never
    // raises sec_tick, so loading the alarm time does not ring.
    assign match = sec_tick && (ss == '0) &&
                   (hh == alarm_q.hh) && (mm == alarm_q.mm);

    // Saturating decrements; zero is the expiry condition.
    assign ring_dec = (ring_q != '0) ? ring_q - 1'b1 : '0;
    assign snz_dec  = (snz_q  != '0) ? snz_q  - 1'b1 : '0;

    // Alarm register load; out-of-range values are dropped.
    always_comb begin
        alarm_d = alarm_q;
        if (set_alarm && hm_valid(alarm_hh, alarm_mm)) begin
            alarm_d.hh = alarm_hh;
            alarm_d.mm = alarm_mm;
        end
    end

    // FSM and second counters; disarming overrides everything.
    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        if (!arm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (match) begin
                        state_d = ST_RINGING;
                        ring_d  = RING_LOAD;
                    end
                end
                ST_RINGING: begin
                    if (dismiss) begin
                        state_d = ST_ARMED;
                    end else if (snooze) begin
                        state_d = ST_SNOOZE;
                        snz_d   = SNZ_LOAD;
                    end else if (sec_tick) begin
                        ring_d = ring_dec;
                        if (ring_dec == '0) begin
                            state_d = ST_ARMED;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (dismiss) begin
                        state_d = ST_ARMED;
                    end else if (sec_tick) begin
                        snz_d = snz_dec;
                        if (snz_dec == '0) begin
                            state_d = ST_RINGING;
                            ring_d  = RING_LOAD;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            alarm_q <= '0;
            state_q <= ST_IDLE;
            ring_q  <= '0;
            snz_q   <= '0;
        end else begin
            alarm_q <= alarm_d;
            state_q <= state_d;
            ring_q  <= ring_d;
            snz_q   <= snz_d;
        end
    end

    // Enable is a pure decode of the registered state, so reset drops it at once.
    assign enable = (state_q == ST_RINGING);
    assign state  = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios followed by a random phase,
// every cycle compared against a seconds-of-day reference model.
module tb_alarm_controller;

    localparam int CPS  = 4;
    localparam int SNZ  = 3;
    localparam int RING = 5;

    localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       arm = 1'b0, set_time = 1'b0, set_alarm = 1'b0;
    logic       snooze = 1'b0, dismiss = 1'b0;
    logic [4:0] time_hh = '0, alarm_hh = '0;
    logic [5:0] time_mm = '0, alarm_mm = '0;
    logic       enable, sec_tick;
    logic [4:0] hh;
    logic [5:0] mm, ss;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    // Reference model: time as seconds of day, alarm as minute of day.
    int m_pre, m_tod, m_alarm, m_st, m_ring, m_snz;
    bit m_tick;

    alarm_controller #(
        .CLK_PER_SEC      (CPS),
        .SNOOZE_SEC       (SNZ),
        .RING_TIMEOUT_SEC (RING)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .arm       (arm),
        .set_time  (set_time),
        .time_hh   (time_hh),
        .time_mm   (time_mm),
        .set_alarm (set_alarm),
        .alarm_hh  (alarm_hh),
        .alarm_mm  (alarm_mm),
        .snooze    (snooze),
        .dismiss   (dismiss),
        .enable    (enable),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .sec_tick  (sec_tick),
        .state     (state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_tod = 0; m_alarm = 0; m_st = M_IDLE;
        m_ring = 0; m_snz = 0; m_tick = 0;
    endtask

    // Apply one clock edge of the behavioural rules to the model.
    task automatic model_edge();
        bit tick_now;
        bit match;
        tick_now = m_tick;
        match    = m_tick && (m_tod % 60 == 0) && (m_tod / 60 == m_alarm);
        if (!arm) m_st = M_IDLE;
        else if (m_st == M_IDLE) m_st = M_ARMED;
        else if (m_st == M_ARMED) begin
            if (match) begin m_st = M_RING; m_ring = RING; end
        end else if (m_st == M_RING) begin
            if (dismiss) m_st = M_ARMED;
            else if (snooze) begin m_st = M_SNZ; m_snz = SNZ; end
            else if (tick_now) begin
                m_ring = m_ring - 1;
                if (m_ring == 0) m_st = M_ARMED;
            end
        end else begin
            if (dismiss) m_st = M_ARMED;
            else if (tick_now) begin
                m_snz = m_snz - 1;
                if (m_snz == 0) begin m_st = M_RING; m_ring = RING; end
            end
        end
        if (set_time && time_hh <= 23 && time_mm <= 59) begin
            m_tod = time_hh * 3600 + time_mm * 60;
            m_pre = 0; m_tick = 0;
        end else if (m_pre == CPS - 1) begin
            m_pre = 0; m_tick = 1;
            m_tod = (m_tod + 1) % 86400;
        end else begin
            m_pre++; m_tick = 0;
        end
        if (set_alarm && alarm_hh <= 23 && alarm_mm <= 59)
            m_alarm = alarm_hh * 60 + alarm_mm;
    endtask

    task automatic check_all();
        chk("state",    state,    m_st);
        chk("enable",   enable,   (m_st == M_RING) ? 1 : 0);
        chk("hh",       hh,       m_tod / 3600);
        chk("mm",       mm,       (m_tod / 60) % 60);
        chk("ss",       ss,       m_tod % 60);
        chk("sec_tick", sec_tick, m_tick);
    endtask

    // One clock: edge, model update, check on the falling edge, clear pulses.
    task automatic cyc();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
        set_time = 0; set_alarm = 0; snooze = 0; dismiss = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_set_time(input int h, input int m);
        time_hh = 5'(h); time_mm = 6'(m); set_time = 1; cyc();
    endtask

    task automatic do_set_alarm(input int h, input int m);
        alarm_hh = 5'(h); alarm_mm = 6'(m); set_alarm = 1; cyc();
    endtask

    // Load 07:29:00 and run to the cycle after the 07:30:00 tick.
    task automatic ring_up(input string tag);
        do_set_time(7, 29);
        run(60 * CPS);
        chk({tag, "_pre_ring_en"}, enable, 0);
        chk({tag, "_pre_ring_tick"}, sec_tick, 1);
        cyc();
        chk({tag, "_ring_en"}, enable, 1);
        chk({tag, "_ring_st"}, state, M_RING);
    endtask

    initial begin
        int nticks;
        int last;
        model_reset();
        #12;
        chk("rst_state", state, 0);
        chk("rst_enable", enable, 0);
        chk("rst_time", {hh, mm, ss}, 0);
        chk("rst_tick", sec_tick, 0);
        @(negedge CLK);
        RST_N = 1;

        // 1: rollover 23:59:xx -> 00:00:00 with regular ticks
        do_set_time(23, 59);
        nticks = 0; last = -1;
        for (int i = 0; i < 60 * CPS; i++) begin
            cyc();
            if (sec_tick) begin
                if (last >= 0) chk("tick_gap", i - last, CPS);
                last = i; nticks++;
            end
        end
        chk("t1_ticks", nticks, 60);
        chk("t1_time", {hh, mm, ss}, 0);
        chk("t1_tick", sec_tick, 1);

        // 2: alarm 07:30, ring, then unattended timeout
        do_set_alarm(7, 30);
        arm = 1;
        ring_up("t2");
        run(RING * CPS - 1);
        chk("t2_last_ring", enable, 1);
        cyc();
        chk("t2_timeout_en", enable, 0);
        chk("t2_timeout_st", state, M_ARMED);

        // 3: snooze, re-ring after SNZ ticks, dismiss
        ring_up("t3");
        snooze = 1; cyc();
        chk("t3_snz_en", enable, 0);
        chk("t3_snz_st", state, M_SNZ);
        run(SNZ * CPS - 2);
        chk("t3_snz_hold", state, M_SNZ);
        cyc();
        chk("t3_rering", enable, 1);
        dismiss = 1; cyc();
        chk("t3_dis_en", enable, 0);
        chk("t3_dis_st", state, M_ARMED);

        // 4: snooze+dismiss together, then disarm while ringing
        ring_up("t4a");
        snooze = 1; dismiss = 1; cyc();
        chk("t4_both_st", state, M_ARMED);
        ring_up("t4b");
        arm = 0; cyc();
        chk("t4_disarm_st", state, M_IDLE);
        chk("t4_disarm_en", enable, 0);
        arm = 1; cyc();

        // 5: out-of-range loads ignored; loading the alarm time does not ring
        do_set_time(24, 0);
        do_set_alarm(12, 60);
        chk("t5_hh_kept", hh, m_tod / 3600);
        do_set_time(7, 30);
        run(3 * CPS);
        chk("t5_no_ring", state, M_ARMED);
        ring_up("t5");

        // 6: asynchronous reset while ringing
        #2 RST_N = 0;
        #1;
        chk("t6_en", enable, 0);
        chk("t6_time", {hh, mm, ss}, 0);
        model_reset();
        @(negedge CLK);
        RST_N = 1;
        chk("t6_st", state, M_IDLE);
        run(4);

        // Random phase
        do_set_alarm(11, 0);
        do_set_time(10, 59);
        for (int i = 0; i < 1200; i++) begin
            arm     = ($urandom_range(0, 199) != 0);
            snooze  = ($urandom_range(0, 19) == 0);
            dismiss = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 399) == 0) begin
                time_hh = 5'($urandom_range(0, 25));
                time_mm = 6'($urandom_range(0, 61));
                set_time = 1;
            end
            if ($urandom_range(0, 399) == 0) begin
                alarm_hh = 5'($urandom_range(0, 25));
                alarm_mm = 6'($urandom_range(0, 61));
                set_alarm = 1;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
